// File: rtl/axil_lite_slv_regfile_pkg.sv
// Shared types and helpers for the AXI-Lite register-file responder.
package axil_lite_slv_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

  // Byte-offset bit count of one data word.
  function automatic int unsigned calc_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_lite_slv_wait_cnt.sv
// Loadable down-counter delaying a channel response; zero_c flags expiry.
module axil_lite_slv_wait_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/axil_lite_slv_regfile.sv
// AXI-Lite responder backed by a word-addressed register array.
// Optional response delay enabled by macro AXIL_LITE_SLV_REGFILE_WAIT_EN.
module axil_lite_slv_regfile
  import axil_lite_slv_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned RESP_WAIT  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = calc_lsb(DATA_WIDTH);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned SPAN   = NUM_REGS * STRB_W;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  // Held beats take priority; a fresh handshake supplies whatever is missing.
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign ar_hs       = arvalid && arready;
  assign commit      = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr     = aw_held ? aw_addr_q : awaddr;
  assign wr_data     = w_held ? w_data_q : wdata;
  assign wr_strb     = w_held ? w_strb_q : wstrb;
  assign wr_in_range = wr_addr < ADDR_WIDTH'(SPAN);
  assign rd_in_range = araddr < ADDR_WIDTH'(SPAN);
  assign wr_idx      = wr_addr[LSB +: IDX_W];
  assign rd_idx      = araddr[LSB +: IDX_W];

`ifdef AXIL_LITE_SLV_REGFILE_WAIT_EN
  localparam bit          WAIT_ON = (RESP_WAIT != 0);
  localparam int unsigned CNT_W   = (RESP_WAIT > 0) ? $clog2(RESP_WAIT + 1) : 1;

  logic wr_zero_c, rd_zero_c;

  axil_lite_slv_wait_cnt #(.WIDTH(CNT_W)) u_wr_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (commit),
    .load_val (CNT_W'(RESP_WAIT)),
    .dec      (wr_state == WR_WAIT),
    .zero_c   (wr_zero_c)
  );

  axil_lite_slv_wait_cnt #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (ar_hs),
    .load_val (CNT_W'(RESP_WAIT)),
    .dec      (rd_state == RD_WAIT),
    .zero_c   (rd_zero_c)
  );
`else
  logic [31:0] unused_resp_wait;
  assign unused_resp_wait = 32'(RESP_WAIT);
`endif

  // Register array: byte-lane write on an in-range commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Write channel FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state  <= WR_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bresp   <= wr_in_range ? OKAY : SLVERR;
`ifdef AXIL_LITE_SLV_REGFILE_WAIT_EN
            if (WAIT_ON) begin
              wr_state <= WR_WAIT;
            end else begin
              bvalid   <= 1'b1;
              wr_state <= WR_RESP;
            end
`else
            bvalid   <= 1'b1;
            wr_state <= WR_RESP;
`endif
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= awaddr;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= wdata;
              w_strb_q <= wstrb;
            end
            awready <= !(aw_held || aw_hs);
            wready  <= !(w_held || w_hs);
          end
        end
`ifdef AXIL_LITE_SLV_REGFILE_WAIT_EN
        WR_WAIT: begin
          if (wr_zero_c) begin
            bvalid   <= 1'b1;
            wr_state <= WR_RESP;
          end
        end
`endif
        WR_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read channel FSM; data is captured at the address handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            arready <= 1'b0;
            rdata   <= rd_in_range ? regs[rd_idx] : '0;
            rresp   <= rd_in_range ? OKAY : SLVERR;
`ifdef AXIL_LITE_SLV_REGFILE_WAIT_EN
            if (WAIT_ON) begin
              rd_state <= RD_WAIT;
            end else begin
              rvalid   <= 1'b1;
              rd_state <= RD_RESP;
            end
`else
            rvalid   <= 1'b1;
            rd_state <= RD_RESP;
`endif
          end else begin
            arready <= 1'b1;
          end
        end
`ifdef AXIL_LITE_SLV_REGFILE_WAIT_EN
        RD_WAIT: begin
          if (rd_zero_c) begin
            rvalid   <= 1'b1;
            rd_state <= RD_RESP;
          end
        end
`endif
        RD_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axil_lite_slv_regfile.md
Name: axil_lite_slv_regfile

Overview:
AXI-Lite responder (slave end) backed by a flat word-addressed register array.
- Accepts write address/data in any order, returns a B response, and serves reads with R responses.
- Used as a self-contained DUT/loopback target for the AXI-Lite agent's master-mode driver and monitor.
- Decodes addresses, applies byte strobes, and flags out-of-range accesses with SLVERR.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr (≤ UVMA_AXIL_ADDR_MAX_SIZE)
DATA_WIDTH, 32, width of wdata/rdata; 32 or 64 only
NUM_REGS, 16, number of DATA_WIDTH-bit registers; power of 2, ≥2
RESP_WAIT, 2, extra cycles before bvalid/rvalid (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
awaddr  input  ADDR_WIDTH  write address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  DATA_WIDTH  write data
wstrb  input  DATA_WIDTH/8  write byte strobes
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  ADDR_WIDTH  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DATA_WIDTH  read data
rresp  output  2  read response
rvalid  output  1  read response valid
rready  input  1  read response ready

Behaviour:
- Reset (async assert, sync release): all registers = 0; awready, wready, arready, bvalid, rvalid = 0; bresp = rresp = 2'b00; rdata = 0; pending AW/W dropped, FSMs to IDLE. Reset mid-transaction aborts it with no response. Readies rise the first cycle after reset release.
- Decode: LSB = log2(DATA_WIDTH/8); idx = addr[LSB +: log2(NUM_REGS)]. In range iff addr < NUM_REGS*(DATA_WIDTH/8). Unaligned low bits are ignored.
- Write FSM states: WR_IDLE, WR_WAIT (feature only), WR_RESP.
  - In WR_IDLE: awready = !aw_held; wready = !w_held.
  - AW and W are captured independently; aw_held and w_held flags record a captured beat.
  - Commit at the edge where both are held or handshaking (same-cycle AW+W allowed). At that edge:
    - In range: write wdata byte lanes where wstrb=1; bresp=OKAY.
    - Out of range: no write; bresp=SLVERR (2'b10).
  - After commit, clear flags and go to WR_RESP. bvalid=1 there; awready=wready=0.
  - bvalid holds until bready is sampled high, then return to WR_IDLE. bresp is stable while bvalid=1.
  - Latency: AW+W handshake at edge N → bvalid=1 after edge N.
- Read FSM states: RD_IDLE, RD_WAIT (feature only), RD_RESP.
  - arready=1 only in RD_IDLE.
  - On handshake: register rdata = reg[idx] (0 if out of range), rresp = OKAY/SLVERR.
  - Go to RD_RESP with rvalid=1; hold rdata/rresp stable until rready, then RD_IDLE.
- Read and write channels run concurrently.
  - Read handshake on the same edge as a write commit to the same register returns the old value.
- Max one outstanding transaction per channel. No EXOKAY/DECERR generated.
- Valid is never dropped before its ready; an input valid without ready is simply held off.

Optional Feature:
Macro AXIL_LITE_SLV_REGFILE_WAIT_EN.
- Defined: commit/read-capture enters WR_WAIT/RD_WAIT. A per-channel down-counter is loaded with RESP_WAIT; bvalid/rvalid assert the cycle after the counter hits 0. RESP_WAIT=0 behaves like undefined.
- Undefined: no WAIT states, no counters; RESP_WAIT ignored; latency exactly as in Behaviour.

Decomposition:
- Package axil_lite_slv_regfile_pkg holds:
  - resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - wr_state_t, rd_state_t
  - function computing LSB from DATA_WIDTH
- One natural sub-module, axil_lite_slv_wait_cnt: load/decrement/zero-flag counter, instantiated once per channel under the macro.

Test Plan:
- AW 0x08 and W 0xDEADBEEF, strb 4'hF, same cycle; bready=1 → bvalid one cycle later, bresp=00. Read 0x08 → rdata=0xDEADBEEF, rresp=00.
- W(0x11223344, strb 4'b0101) three cycles before AW 0x04 → awready stays 1, wready=0 until commit. Read 0x04 → 0x00220044.
- Write to 0x40 with NUM_REGS=16 → bresp=10, no register changes. Read 0x40 → rdata=0, rresp=10.
- rready held 0 for 5 cycles → rvalid, rdata, rresp stable; arready=0 throughout; next AR accepted the cycle after rready.
- reset_n pulsed low during WR_RESP → bvalid=0 immediately, registers 0. After release, read 0x08 → 0.
- With WAIT_EN and RESP_WAIT=3: write handshake at edge N → bvalid rises after edge N+4. Concurrent read to the same address returns the pre-write value.
